// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the tri-state bus mux arbiter.
package mux_arb_pkg;

    localparam int unsigned BEAT_W = 4;
    localparam int unsigned GAP_W  = 2;

    // Owner encoding doubles as the mux select value
    localparam logic OWNER_A = 1'b0;
    localparam logic OWNER_B = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2,
        TURN  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/mux_bus_arbiter_rr_pick.sv
// Round-robin pick between two requesters; on a tie the non-last owner wins.
module rr_pick
    import mux_arb_pkg::*;
(
    input  logic req_a,
    input  logic req_b,
    input  logic last_owner,
    output logic valid,
    output logic winner
);

    // Combinational winner selection
    always_comb begin
        valid  = req_a | req_b;
        winner = OWNER_A;
        if (req_a && req_b) begin
            winner = ~last_owner;
        end else if (req_b) begin
            winner = OWNER_B;
        end
    end

endmodule

// File: rtl/mux_bus_arbiter.sv
// Round-robin burst arbiter driving the select/enable of an 8-bit tri-state 2:1 mux,
// with bus-idle turnaround cycles between owners.
// Optional macro MUX_ARB_BURST_LIMIT_EN enables the MAX_BURST forced release.
module mux_bus_arbiter
    import mux_arb_pkg::*;
#(
    parameter int unsigned MAX_BURST  = 8,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_a,
    input  logic              req_b,
    input  logic              last_a,
    input  logic              last_b,
    output logic              gnt_a,
    output logic              gnt_b,
    output logic              sel,
    output logic              bus_en,
    output logic [BEAT_W-1:0] beat_cnt,
    output logic              forced
);

    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

    arb_state_e        state_q;
    logic              gnt_a_q, gnt_b_q, sel_q, bus_en_q, forced_q, last_owner_q;
    logic [BEAT_W-1:0] beat_cnt_q;
    logic [GAP_W-1:0]  gap_q;

    logic              own_c, cur_owner_c, cur_req_c, cur_last_c;
    logic              limit_hit_c, release_c, pick_last_c, pick_valid_c, pick_winner_c, arb_go_c;
    logic [BEAT_W-1:0] beat_next_c;

    // Current-owner view, release decision and beat counter next value
    always_comb begin
        own_c       = (state_q == OWN_A) || (state_q == OWN_B);
        cur_owner_c = (state_q == OWN_B) ? OWNER_B : OWNER_A;
        cur_req_c   = cur_owner_c ? req_b : req_a;
        cur_last_c  = cur_owner_c ? last_b : last_a;
`ifdef MUX_ARB_BURST_LIMIT_EN
        beat_next_c = beat_cnt_q + BEAT_W'(1);
        limit_hit_c = cur_req_c && (beat_cnt_q == BEAT_W'(MAX_BURST - 1));
`else
        beat_next_c = (beat_cnt_q == {BEAT_W{1'b1}}) ? beat_cnt_q : beat_cnt_q + BEAT_W'(1);
        limit_hit_c = 1'b0;
`endif
        release_c   = own_c && (!cur_req_c || cur_last_c || limit_hit_c);
        // While owning, the releasing owner is the reference for the immediate (no-gap) pick
        pick_last_c = own_c ? cur_owner_c : last_owner_q;
    end

`ifndef MUX_ARB_BURST_LIMIT_EN
    // Keeps MAX_BURST referenced when the cut-off is compiled out
    logic [BEAT_W-1:0] unused_burst_c;
    assign unused_burst_c = BEAT_W'(MAX_BURST);
`endif

    rr_pick u_rr_pick (
        .req_a      (req_a),
        .req_b      (req_b),
        .last_owner (pick_last_c),
        .valid      (pick_valid_c),
        .winner     (pick_winner_c)
    );

    // Arbitration happens in IDLE, at the end of TURN, or at release when there is no gap
    always_comb begin
        arb_go_c = pick_valid_c &&
                   ((state_q == IDLE) ||
                    ((state_q == TURN) && (gap_q == GAP_LAST)) ||
                    (release_c && (GAP_CYCLES == 0)));
    end

    // Arbiter FSM with registered outputs; a new grant overrides the release updates
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            gnt_a_q      <= 1'b0;
            gnt_b_q      <= 1'b0;
            sel_q        <= 1'b0;
            bus_en_q     <= 1'b0;
            forced_q     <= 1'b0;
            beat_cnt_q   <= '0;
            gap_q        <= '0;
            last_owner_q <= OWNER_B;
        end else begin
            forced_q <= 1'b0;
            case (state_q)
                TURN: begin
                    if (gap_q == GAP_LAST) begin
                        state_q <= IDLE;
                    end else begin
                        gap_q <= gap_q + GAP_W'(1);
                    end
                end
                OWN_A, OWN_B: begin
                    if (cur_req_c) begin
                        beat_cnt_q <= beat_next_c;
                    end
                    if (release_c) begin
                        last_owner_q <= cur_owner_c;
                        forced_q     <= limit_hit_c;
                        gnt_a_q      <= 1'b0;
                        gnt_b_q      <= 1'b0;
                        bus_en_q     <= 1'b0;
                        gap_q        <= '0;
                        state_q      <= (GAP_CYCLES == 0) ? IDLE : TURN;
                    end
                end
                default: ;
            endcase
            if (arb_go_c) begin
                state_q    <= pick_winner_c ? OWN_B : OWN_A;
                gnt_a_q    <= ~pick_winner_c;
                gnt_b_q    <= pick_winner_c;
                sel_q      <= pick_winner_c;
                bus_en_q   <= 1'b1;
                beat_cnt_q <= '0;
            end
        end
    end

    assign gnt_a    = gnt_a_q;
    assign gnt_b    = gnt_b_q;
    assign sel      = sel_q;
    assign bus_en   = bus_en_q;
    assign beat_cnt = beat_cnt_q;
    assign forced   = forced_q;

endmodule

// File: tb/tb_mux_bus_arbiter.sv
// Directed bench for mux_bus_arbiter: one instance with a 1-cycle gap, one with no gap.
module tb_mux_bus_arbiter;

    logic       clk;
    logic       rst_n;
    logic       req_a, req_b, last_a, last_b;
    logic       gnt_a, gnt_b, sel, bus_en, forced;
    logic [3:0] beat_cnt;
    logic       req_a2, req_b2, last_a2, last_b2;
    logic       gnt_a2, gnt_b2, sel2, bus_en2, forced2;
    logic [3:0] beat_cnt2;

    int n_total;
    int n_bad;

    mux_bus_arbiter #(.MAX_BURST(4), .GAP_CYCLES(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a), .req_b(req_b), .last_a(last_a), .last_b(last_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .sel(sel), .bus_en(bus_en),
        .beat_cnt(beat_cnt), .forced(forced)
    );

    mux_bus_arbiter #(.MAX_BURST(4), .GAP_CYCLES(0)) u_dut_nogap (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a2), .req_b(req_b2), .last_a(last_a2), .last_b(last_b2),
        .gnt_a(gnt_a2), .gnt_b(gnt_b2), .sel(sel2), .bus_en(bus_en2),
        .beat_cnt(beat_cnt2), .forced(forced2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Expected output vector {gnt_a, gnt_b, sel, bus_en, beat_cnt, forced}
    function automatic logic [15:0] ov(input logic ga, input logic gb, input logic s,
                                       input logic be, input logic [3:0] bc, input logic f);
        return {7'd0, ga, gb, s, be, bc, f};
    endfunction

    function automatic logic [15:0] obs1();
        return {7'd0, gnt_a, gnt_b, sel, bus_en, beat_cnt, forced};
    endfunction

    function automatic logic [15:0] obs2();
        return {7'd0, gnt_a2, gnt_b2, sel2, bus_en2, beat_cnt2, forced2};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_a = 0; req_b = 0; last_a = 0; last_b = 0;
        req_a2 = 0; req_b2 = 0; last_a2 = 0; last_b2 = 0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        logic o;
        n_total = 0;
        n_bad   = 0;
        clk     = 1'b0;

        // Reset values
        do_reset();
        chk("reset_dut", obs1(), ov(0, 0, 0, 0, 4'd0, 0));
        chk("reset_nogap", obs2(), ov(0, 0, 0, 0, 4'd0, 0));

        // Single A burst of 3 beats, then 1 turnaround cycle, then idle
        req_a = 1;
        tick();
        chk("a_grant", obs1(), ov(1, 0, 0, 1, 4'd0, 0));
        tick();
        chk("a_beat1", obs1(), ov(1, 0, 0, 1, 4'd1, 0));
        tick();
        chk("a_beat2", obs1(), ov(1, 0, 0, 1, 4'd2, 0));
        last_a = 1;
        tick();
        chk("a_release", obs1(), ov(0, 0, 0, 0, 4'd3, 0));
        req_a = 0; last_a = 0;
        tick();
        chk("a_turn_end", obs1(), ov(0, 0, 0, 0, 4'd3, 0));
        tick();
        chk("a_idle", obs1(), ov(0, 0, 0, 0, 4'd3, 0));

        // Both requesting, 2-beat bursts: A, B, A, B with one idle cycle per switch
        do_reset();
        req_a = 1; req_b = 1;
        for (int r = 0; r < 4; r++) begin
            o = r[0];
            tick();
            chk($sformatf("rr%0d_grant", r), obs1(), ov(~o, o, o, 1, 4'd0, 0));
            tick();
            chk($sformatf("rr%0d_beat1", r), obs1(), ov(~o, o, o, 1, 4'd1, 0));
            if (o) last_b = 1; else last_a = 1;
            tick();
            chk($sformatf("rr%0d_gap", r), obs1(), ov(0, 0, o, 0, 4'd2, 0));
            last_a = 0; last_b = 0;
        end

        // B holds the bus with no last
        do_reset();
        req_b = 1;
        tick();
        chk("b_grant", obs1(), ov(0, 1, 1, 1, 4'd0, 0));
        tick();
        tick();
        tick();
        chk("b_beat3", obs1(), ov(0, 1, 1, 1, 4'd3, 0));
        tick();
`ifdef MUX_ARB_BURST_LIMIT_EN
        chk("b_forced", obs1(), ov(0, 0, 1, 0, 4'd4, 1));
        tick();
        chk("b_regrant", obs1(), ov(0, 1, 1, 1, 4'd0, 0));
`else
        chk("b_beat4", obs1(), ov(0, 1, 1, 1, 4'd4, 0));
        repeat (11) tick();
        chk("b_beat15", obs1(), ov(0, 1, 1, 1, 4'd15, 0));
        repeat (3) tick();
        chk("b_saturate", obs1(), ov(0, 1, 1, 1, 4'd15, 0));
`endif

        // No-gap instance: A releases while B requests, bus stays enabled
        do_reset();
        req_a2 = 1;
        tick();
        chk("ng_a_grant", obs2(), ov(1, 0, 0, 1, 4'd0, 0));
        req_b2 = 1; last_a2 = 1;
        tick();
        chk("ng_b_grant", obs2(), ov(0, 1, 1, 1, 4'd0, 0));
        req_a2 = 0; last_a2 = 0;
        tick();
        chk("ng_b_beat1", obs2(), ov(0, 1, 1, 1, 4'd1, 0));

        // Reset mid-burst on A, then a tie is won by A
        do_reset();
        req_a = 1;
        tick();
        tick();
        chk("mid_burst", obs1(), ov(1, 0, 0, 1, 4'd1, 0));
        rst_n = 0;
        tick();
        chk("mid_reset", obs1(), ov(0, 0, 0, 0, 4'd0, 0));
        rst_n = 1; req_a = 1; req_b = 1;
        tick();
        chk("tie_after_reset", obs1(), ov(1, 0, 0, 1, 4'd0, 0));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/mux_bus_arbiter.md
# mux_bus_arbiter

Sequencing controller for the team's 8-bit tri-state 2:1 bus multiplexer (w = s ? b : a when en=1, high-Z when en=0). It shares the multiplexed bus between two requesters, A (mux input a) and B (mux input b), using round-robin bursts. It drives the mux select and enable pins directly. It inserts bus-idle turnaround cycles between owners so the tri-state output never switches source while driving.

## Interface
- MAX_BURST, 8: beats per grant before forced release (1..15)
- GAP_CYCLES, 1: turnaround cycles with bus_en=0 between grants (0..3)
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- req_a / req_b  in  1  requester wants or holds the bus; one beat per cycle while granted
- last_a / last_b  in  1  final beat of burst; qualified by req_x
- gnt_a / gnt_b  out  1  ownership; at most one high
- sel  out  1  to mux s: 0 = a, 1 = b
- bus_en  out  1  to mux en; high exactly when gnt_a|gnt_b
- beat_cnt  out  4  beats completed in current grant
- forced  out  1  one-cycle pulse: grant cut by burst limit

## Operation
- Reset values: gnt_a=gnt_b=0, sel=0, bus_en=0, beat_cnt=0, forced=0, state IDLE, last_owner=B, so A wins the first tie.
- States: IDLE, OWN_A, OWN_B, TURN.
- IDLE transitions:
  - One requester high: grant it.
  - Both high: grant the requester that is not last_owner.
  - Neither high: stay in IDLE.
- OWN_x: each cycle with req_x=1 is one beat, and beat_cnt increments.
- OWN_x releases when any of these holds:
  - req_x=1 and last_x=1 (the beat counts);
  - req_x=0 (no beat);
  - beat_cnt reaches MAX_BURST, which also pulses forced.
- On release: last_owner=x, then go to TURN. If GAP_CYCLES=0, TURN is skipped and arbitration is immediate.
- TURN: bus_en=0, both gnt=0, sel holds its last value. After GAP_CYCLES cycles, arbitrate as in IDLE. The other requester has priority; if only x requests, x is re-granted.
- sel changes only in the cycle a new grant takes effect. It never changes while bus_en stays high across the same owner.
- beat_cnt clears to 0 at each new grant.
- Reset mid-burst: all outputs return to reset values at the next clk edge, and the bus goes high-Z. No release bookkeeping is performed.

## Timing
- All outputs are registered.
- Grant latency: req sampled at edge n in IDLE → gnt, bus_en, sel valid after edge n+1.
- Release: last beat sampled at edge m → gnt and bus_en low after edge m+1.
- Next grant: valid after edge m+1+GAP_CYCLES. For GAP_CYCLES=0, the next owner's gnt is high after edge m+1 with no idle cycle.
- Forced release: the MAX_BURST-th beat is accepted. forced=1 during the cycle after that beat, the same cycle gnt drops.
- Simultaneous requests on the release cycle are resolved at the end of TURN, not earlier.

## Configuration
- MUX_ARB_BURST_LIMIT_EN defined: the MAX_BURST cut-off is active, and forced can pulse.
- MUX_ARB_BURST_LIMIT_EN undefined: grants end only on last_x or on req_x drop.
  - forced is tied to 0.
  - beat_cnt saturates at 15.

## Structure
- Package mux_arb_pkg holds:
  - the state enum (IDLE, OWN_A, OWN_B, TURN);
  - the beat counter width constant (4);
  - the owner encoding constants OWNER_A=0 and OWNER_B=1, matching the sel polarity.
- Sub-module rr_pick (combinational): inputs req_a, req_b, last_owner; outputs valid and winner.

## Test plan
- After reset, req_a=1 at edge 2 → gnt_a=1, sel=0, bus_en=1 after edge 3. last_a on the 3rd beat → bus_en=0 for 1 cycle, then IDLE.
- req_a and req_b both held with 2-beat bursts → grants alternate A, B, A, B. Each switch has exactly GAP_CYCLES cycles with bus_en=0, and sel toggles only on grant edges.
- MUX_ARB_BURST_LIMIT_EN defined, MAX_BURST=4, req_b held with no last → 4 beats, then forced=1 for one cycle. If A is idle, B is re-granted after the gap.
- Same stimulus with the macro undefined → B keeps the bus, beat_cnt saturates at 15, forced stays 0.
- GAP_CYCLES=0, A releases while B requests → gnt_b=1 on the cycle immediately after gnt_a=0, and bus_en stays 1 across the switch.
- rst_n=0 mid-burst on A → after the next edge all outputs are 0. A tie after reset release is won by A.
